// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter slice.
package mem_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int MAX_NUM_REQ    = 4;

  // Tag index is sized for the largest supported requester count so the
  // struct stays a fixed package type; smaller configurations zero-extend.
  localparam int TAG_IDX_W = $clog2(MAX_NUM_REQ);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // One entry of the read-return tag pipeline: which requester owns the
  // read currently travelling through the memory.
  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  // Pointer width; a single requester still gets a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter.
//
// Handshake: a requester raises req[i] together with req_we/req_addr/req_data
// slice i and holds all of them stable until it sees gnt[i]=1 in the same
// cycle; the access is consumed at the clock edge ending that cycle. A read
// returns exactly once as a one-cycle rsp_valid[i] strobe with rsp_data; there
// is no back-pressure on responses.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          halted;

  logic [ADDR_WIDTH-1:0]         mem_address;
  logic [DATA_WIDTH-1:0]         mem_data;
  logic                          mem_write;
  logic                          mem_read;
  logic [DATA_WIDTH-1:0]         mem_data_out;
  logic                          mem_valid;
  logic                          mem_err;

  // Arbiter view.
  modport slave (
    input  req, req_we, req_addr, req_data,
    input  mem_data_out, mem_valid, mem_err,
    output gnt, rsp_valid, rsp_data, halted,
    output mem_address, mem_data, mem_write, mem_read
  );

  // Requesters plus memory view.
  modport master (
    output req, req_we, req_addr, req_data,
    output mem_data_out, mem_valid, mem_err,
    input  gnt, rsp_valid, rsp_data, halted,
    input  mem_address, mem_data, mem_write, mem_read
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin pick: search starts one past the last winner and wraps.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int N  = DEF_NUM_REQ,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_next_ptr
);

  // (base + step) mod N, returned at pointer width.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base,
                                             input int unsigned   step);
    int unsigned sum;
    sum = (32'(base) + step) % 32'(N);
    return PW'(sum);
  endfunction

  // First asserted request after the pointer wins; pointer follows the winner.
  always_comb begin
    logic          found;
    logic [PW-1:0] cand;
    o_gnt      = '0;
    o_next_ptr = i_ptr;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = wrap_idx(i_ptr, k);
      if (!found && i_req[cand]) begin
        found       = 1'b1;
        o_gnt[cand] = 1'b1;
        o_next_ptr  = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port memory between requesters.
// One access per cycle, registered memory command, read results routed back
// through a two-stage tag pipeline; any memory error parks the block in HALT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         RESET_L,
  mem_arbiter_if.slave bus,
  output state_t       o_dbg_state
);

  localparam int PW = ptr_width(NUM_REQ);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         w_arb_next_ptr;
  logic [NUM_REQ-1:0]    w_arb_gnt;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_any_gnt;
  logic                  w_fault;

  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_write;
  logic                  r_mem_read;

  tag_t                  r_tag1;
  tag_t                  r_tag2;
  tag_t                  w_tag_new;

  logic [NUM_REQ-1:0]    w_rsp_valid;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req      (bus.req),
    .i_ptr      (r_ptr),
    .o_gnt      (w_arb_gnt),
    .o_next_ptr (w_arb_next_ptr)
  );

  // A reported error, or a tagged read whose data never showed up, both mean
  // the memory can no longer be trusted.
  assign w_fault = bus.mem_err | (r_tag2.vld & ~bus.mem_valid);

  // FSM next state plus the grant and response outputs it qualifies.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_rsp_valid = '0;
    w_rsp_data  = '0;
    case (r_state)
      ST_RUN: begin
        // Grants are suppressed while reset is held and on a faulting cycle
        // so no new command is launched into a failing memory.
        if (RESET_L && !w_fault) begin
          w_gnt = w_arb_gnt;
        end
        if (r_tag2.vld && bus.mem_valid && !bus.mem_err) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_valid[i] = (r_tag2.idx == TAG_IDX_W'(i));
          end
          w_rsp_data = bus.mem_data_out;
        end
        if (w_fault) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  assign w_any_gnt = |w_gnt;

  // Mux the granted requester's command fields.
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_we   = bus.req_we[i];
        w_sel_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Tag entering the pipeline this cycle: only reads need a return path.
  always_comb begin
    w_tag_new     = '0;
    w_tag_new.vld = w_any_gnt & ~w_sel_we;
    w_tag_new.idx = TAG_IDX_W'(w_arb_next_ptr);
  end

  // State register and round-robin pointer; pointer moves only on a grant.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= ST_RUN;
      r_ptr   <= PW'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_any_gnt) begin
        r_ptr <= w_arb_next_ptr;
      end
    end
  end

  // Registered memory command; write and read come from one we bit so they
  // can never both be high. Address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
    end else begin
      r_mem_write <= w_any_gnt & w_sel_we;
      r_mem_read  <= w_any_gnt & ~w_sel_we;
      if (w_any_gnt) begin
        r_mem_address <= w_sel_addr;
        r_mem_data    <= w_sel_data;
      end
    end
  end

  // Two-stage tag pipe matching the command register plus memory latency;
  // flushed on entry to HALT so in-flight reads are dropped.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else if (w_state_nxt == ST_HALT) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1 <= w_tag_new;
      r_tag2 <= r_tag1;
    end
  end

  assign bus.gnt         = w_gnt;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_data    = w_rsp_data;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data    = r_mem_data;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_read    = r_mem_read;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, requester op queues, and a
// negedge monitor comparing against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int DW  = 6;
  localparam int AW  = 3;
  localparam int OPW = 1 + AW + DW;   // {we, addr, data}
  localparam int EW  = 16 + 2 + DW;   // {due_cycle, idx, data}

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   RESET_L;
  state_t dbg_state;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .RESET_L     (RESET_L),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- behavioural memory ----------------
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  logic [DW-1:0] env_dout;
  logic          env_vld;
  logic          force_err;

  always @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      env_dout <= '0;
      env_vld  <= 1'b0;
      for (int a = 0; a < (1 << AW); a++) env_mem[a] <= '0;
    end else begin
      env_vld <= bus.mem_read;
      if (bus.mem_read)  env_dout <= env_mem[bus.mem_address];
      if (bus.mem_write) env_mem[bus.mem_address] <= bus.mem_data;
    end
  end

  assign bus.mem_data_out = env_dout;
  assign bus.mem_valid    = env_vld;
  assign bus.mem_err      = force_err | (bus.mem_write & bus.mem_read);

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int            m_ptr;
  int            m_w;
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] m_e;
  logic          e_wr, e_rd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(negedge clk) begin
    if (!RESET_L) begin
      m_ptr = N - 1;
      for (int a = 0; a < (1 << AW); a++) model_mem[a] = '0;
      exp_q.delete();
      e_wr = 1'b0;
      e_rd = 1'b0;
    end else if (chk_en) begin
      // command issued for last cycle's grant
      chk("mem_excl", 32'(bus.mem_write & bus.mem_read), 32'(0));
      chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
      chk("mem_read", 32'(bus.mem_read), 32'(e_rd));
      if (e_wr || e_rd) chk("mem_address", 32'(bus.mem_address), 32'(e_addr));
      if (e_wr)         chk("mem_data", 32'(bus.mem_data), 32'(e_data));
      chk("halted", 32'(bus.halted), 32'(0));
      chk("dbg_state", 32'(dbg_state), 32'(ST_RUN));

      // read returns
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 16]) < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_missing: read for requester %0d due at cyc %0d never returned (now %0d)",
                 exp_q[0][DW +: 2], exp_q[0][EW-1 -: 16], cyc);
        void'(exp_q.pop_front());
      end
      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected @cyc %0d: rsp_valid=%b with no read outstanding", cyc, bus.rsp_valid);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(m_e[EW-1 -: 16]));
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << m_e[DW +: 2]);
          chk("rsp_data", 32'(bus.rsp_data), 32'(m_e[DW-1:0]));
        end
      end

      // arbitration: first requester at or after ptr+1 (mod N)
      m_w = -1;
      for (int k = 1; k <= N; k++) begin
        if (m_w < 0 && bus.req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
      end
      chk("gnt", 32'(bus.gnt), (m_w >= 0) ? (32'(1) << m_w) : 32'(0));
      if (m_w >= 0) begin
        m_ptr  = m_w;
        e_addr = bus.req_addr[m_w*AW +: AW];
        e_data = bus.req_data[m_w*DW +: DW];
        e_wr   = bus.req_we[m_w];
        e_rd   = !bus.req_we[m_w];
        if (bus.req_we[m_w]) model_mem[e_addr] = e_data;
        else exp_q.push_back({16'(cyc + 2), 2'(m_w), model_mem[e_addr]});
      end else begin
        e_wr = 1'b0;
        e_rd = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  logic [OPW-1:0] op_q [N][$];

  task automatic run_cycles(input int n);
    logic [N-1:0]   g;
    logic [OPW-1:0] op;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if (op_q[i].size() > 0) begin
          op = op_q[i][0];
          bus.req[i]                 = 1'b1;
          bus.req_we[i]              = op[OPW-1];
          bus.req_addr[i*AW +: AW]   = op[DW +: AW];
          bus.req_data[i*DW +: DW]   = op[DW-1:0];
        end else begin
          bus.req[i] = 1'b0;
        end
      end
      @(negedge clk);
      g = bus.gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g[i] && op_q[i].size() > 0) void'(op_q[i].pop_front());
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((op_q[0].size() + op_q[1].size() + exp_q.size()) > 0 && guard < 300) begin
      run_cycles(1);
      guard++;
    end
    run_cycles(2);
    chk("drain_done", 32'(guard < 300), 32'(1));
  endtask

  task automatic apply_reset(input bit en);
    chk_en    = 1'b0;
    RESET_L   = 1'b0;
    force_err = 1'b0;
    bus.req   = '0;
    repeat (2) @(posedge clk);
    #1;
    RESET_L = 1'b1;
    chk_en  = en;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  int issued;
  int guard;

  initial begin
    RESET_L      = 1'b0;
    force_err    = 1'b0;
    bus.req      = 2'b11;
    bus.req_we   = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    #2;
    // reset state, with requests asserted to show grants are held off
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    chk("rst_halted", 32'(bus.halted), 32'(0));
    chk("rst_mem_write", 32'(bus.mem_write), 32'(0));
    chk("rst_mem_read", 32'(bus.mem_read), 32'(0));
    chk("rst_mem_address", 32'(bus.mem_address), 32'(0));
    chk("rst_mem_data", 32'(bus.mem_data), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
    apply_reset(1'b1);

    // R0 writes addr 3 = 0x2A, later R1 reads it back
    op_q[0].push_back({1'b1, 3'd3, 6'h2A});
    run_cycles(3);
    op_q[1].push_back({1'b0, 3'd3, 6'h00});
    drain();

    // same-cycle write (R0) vs read (R1) of addr 5; pointer favours R0
    op_q[0].push_back({1'b1, 3'd5, 6'h11});
    op_q[1].push_back({1'b0, 3'd5, 6'h00});
    drain();

    // continuous reads from both requesters straight after reset
    apply_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      op_q[0].push_back({1'b0, AW'(k), DW'(0)});
      op_q[1].push_back({1'b0, AW'(7 - k), DW'(0)});
    end
    drain();

    // random mixed traffic
    apply_reset(1'b1);
    issued = 0;
    guard  = 0;
    while (issued < 1000 && guard < 5000) begin
      for (int i = 0; i < N; i++) begin
        if (op_q[i].size() == 0 && $urandom_range(0, 99) < 70) begin
          op_q[i].push_back({1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                             DW'($urandom_range(0, 63))});
          issued++;
        end
      end
      run_cycles(1);
      guard++;
    end
    chk("random_issue_done", 32'(issued >= 1000), 32'(1));
    drain();

    // memory error with two reads in flight
    apply_reset(1'b0);
    bus.req      = 2'b11;
    bus.req_we   = 2'b00;
    bus.req_addr = {3'd2, 3'd1};
    @(negedge clk);
    chk("halt_gnt_r0", 32'(bus.gnt), 32'(2'b01));
    @(posedge clk); #1;
    bus.req = 2'b10;
    @(negedge clk);
    chk("halt_gnt_r1", 32'(bus.gnt), 32'(2'b10));
    @(posedge clk); #1;
    bus.req   = 2'b11;
    force_err = 1'b1;
    @(negedge clk);
    chk("err_cycle_gnt", 32'(bus.gnt), 32'(0));
    chk("err_cycle_rsp", 32'(bus.rsp_valid), 32'(0));
    @(posedge clk); #1;
    force_err = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("halt_halted", 32'(bus.halted), 32'(1));
      chk("halt_gnt", 32'(bus.gnt), 32'(0));
      chk("halt_rsp", 32'(bus.rsp_valid), 32'(0));
      chk("halt_cmd", 32'({bus.mem_write, bus.mem_read}), 32'(0));
      chk("halt_state", 32'(dbg_state), 32'(ST_HALT));
      @(posedge clk); #1;
    end

    // only reset leaves HALT
    apply_reset(1'b0);
    @(negedge clk);
    chk("unhalt_halted", 32'(bus.halted), 32'(0));
    chk("unhalt_state", 32'(dbg_state), 32'(ST_RUN));
    @(posedge clk); #1;

    // reset one cycle after a read grant
    bus.req      = 2'b01;
    bus.req_we   = 2'b00;
    bus.req_addr = {3'd0, 3'd3};
    @(negedge clk);
    chk("midrst_gnt", 32'(bus.gnt), 32'(2'b01));
    @(posedge clk); #1;
    bus.req = 2'b11;
    RESET_L = 1'b0;
    #1;
    chk("midrst_gnt0", 32'(bus.gnt), 32'(0));
    chk("midrst_rsp", 32'(bus.rsp_valid), 32'(0));
    chk("midrst_rsp_data", 32'(bus.rsp_data), 32'(0));
    chk("midrst_halted", 32'(bus.halted), 32'(0));
    chk("midrst_cmd", 32'({bus.mem_write, bus.mem_read}), 32'(0));
    chk("midrst_addr", 32'(bus.mem_address), 32'(0));
    chk("midrst_data", 32'(bus.mem_data), 32'(0));
    @(posedge clk); #1;
    RESET_L = 1'b1;
    bus.req = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("postrst_rsp", 32'(bus.rsp_valid), 32'(0));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
